// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / loader) arbiter for a single-port memory with loader lock and read return.
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed CPU priority with a starvation limit.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_STREAK = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_lock,
    output logic                  ldr_gnt,
    output logic                  ldr_rvalid,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic {
        FREE       = 1'b0,
        LDR_LOCKED = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   arb_free;
    logic   pick_ldr;
    logic   pend_valid;
    logic   pend_ldr;

`ifdef MEM_ARB_RR_EN
    logic last_ldr;
    logic last_ldr_nxt;
`else
    localparam int unsigned STREAK_W = 8;
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
`endif

    // Registered state: ownership, pending read and contention history
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FREE;
            pend_valid <= 1'b0;
            pend_ldr   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_ldr   <= 1'b1;
`else
            streak     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            pend_valid <= (cpu_gnt && !cpu_we) || (ldr_gnt && !ldr_we);
            pend_ldr   <= ldr_gnt;
`ifdef MEM_ARB_RR_EN
            last_ldr   <= last_ldr_nxt;
`else
            streak     <= streak_nxt;
`endif
        end
    end

    // Grant selection, ownership next state and memory port mux
    always_comb begin
        cpu_gnt     = 1'b0;
        ldr_gnt     = 1'b0;
        state_nxt   = state;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;

        // A lock release is arbitrated as FREE in the very cycle it is seen
        arb_free = (state == FREE) || !ldr_lock;

`ifdef MEM_ARB_RR_EN
        pick_ldr     = !last_ldr;
        last_ldr_nxt = last_ldr;
`else
        pick_ldr   = (streak == STREAK_LIMIT);
        streak_nxt = streak;
`endif

        if (!reset) begin
            if (!arb_free) begin
                ldr_gnt = ldr_req;
            end else if (cpu_req && ldr_req) begin
                ldr_gnt = pick_ldr;
                cpu_gnt = !pick_ldr;
            end else begin
                cpu_gnt = cpu_req;
                ldr_gnt = ldr_req;
            end
        end

        if (arb_free) begin
            state_nxt = (ldr_gnt && ldr_lock) ? LDR_LOCKED : FREE;
        end else begin
            state_nxt = LDR_LOCKED;
        end

`ifdef MEM_ARB_RR_EN
        if (ldr_gnt) begin
            last_ldr_nxt = 1'b1;
        end else if (cpu_gnt) begin
            last_ldr_nxt = 1'b0;
        end
`else
        if (ldr_gnt || !ldr_req) begin
            streak_nxt = '0;
        end else if (cpu_gnt) begin
            streak_nxt = streak + STREAK_W'(1);
        end
`endif

        if (cpu_gnt) begin
            mem_wren    = cpu_we;
            mem_address = cpu_addr;
            mem_data    = cpu_wdata;
        end else if (ldr_gnt) begin
            mem_wren    = ldr_we;
            mem_address = ldr_addr;
            mem_data    = ldr_wdata;
        end
    end

    // Read data returns to whoever issued the read; suppressed while in reset
    assign cpu_rvalid = !reset && pend_valid && !pend_ldr;
    assign ldr_rvalid = !reset && pend_valid && pend_ldr;
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign ldr_rdata  = ldr_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned MS = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata, ldr_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_STREAK(MS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_lock   (ldr_lock),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    // Single-port memory with one cycle read latency
    bit [DW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_wren) mem_arr[mem_address] <= mem_data;
        mem_q <= mem_arr[mem_address];
    end

    // Reference model state
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit          m_locked;
    int unsigned m_streak;
    bit          m_last_ldr;
    bit          m_pv, m_pl;
    logic [DW-1:0] m_pd;

    int n_checks;
    int n_fail;

    logic          o_cg, o_lg, o_crv, o_lrv;
    logic [DW-1:0] o_crd, o_lrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model past the edge
    task automatic tick();
        bit free;
        bit eg_c, eg_l, rv_c, rv_l;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        bit e_wren;
        @(negedge clock);
        eg_c = 1'b0;
        eg_l = 1'b0;
        free = !m_locked || !ldr_lock;
        if (!reset) begin
            if (!free) begin
                eg_l = ldr_req;
            end else if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
                eg_l = !m_last_ldr;
`else
                eg_l = (m_streak == MS);
`endif
                eg_c = !eg_l;
            end else begin
                eg_c = cpu_req;
                eg_l = ldr_req;
            end
        end
        e_wren = eg_c ? cpu_we    : (eg_l ? ldr_we    : 1'b0);
        e_addr = eg_c ? cpu_addr  : (eg_l ? ldr_addr  : '0);
        e_data = eg_c ? cpu_wdata : (eg_l ? ldr_wdata : '0);
        rv_c = !reset && m_pv && !m_pl;
        rv_l = !reset && m_pv && m_pl;

        chk("cpu_gnt",     32'(cpu_gnt),     32'(eg_c));
        chk("ldr_gnt",     32'(ldr_gnt),     32'(eg_l));
        chk("mem_wren",    32'(mem_wren),    32'(e_wren));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_data",    32'(mem_data),    32'(e_data));
        chk("cpu_rvalid",  32'(cpu_rvalid),  32'(rv_c));
        chk("ldr_rvalid",  32'(ldr_rvalid),  32'(rv_l));
        chk("cpu_rdata",   32'(cpu_rdata),   32'(rv_c ? m_pd : '0));
        chk("ldr_rdata",   32'(ldr_rdata),   32'(rv_l ? m_pd : '0));

        o_cg  = cpu_gnt;
        o_lg  = ldr_gnt;
        o_crv = cpu_rvalid;
        o_lrv = ldr_rvalid;
        o_crd = cpu_rdata;
        o_lrd = ldr_rdata;

        @(posedge clock);
        if (reset) begin
            m_locked   = 1'b0;
            m_streak   = 0;
            m_last_ldr = 1'b1;
            m_pv       = 1'b0;
            m_pl       = 1'b0;
        end else begin
            m_pv = (eg_c && !cpu_we) || (eg_l && !ldr_we);
            m_pl = eg_l;
            if (eg_c) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        m_pd = ref_mem[cpu_addr];
            end
            if (eg_l) begin
                if (ldr_we) ref_mem[ldr_addr] = ldr_wdata;
                else        m_pd = ref_mem[ldr_addr];
            end
            if (free) m_locked = eg_l && ldr_lock;
            if (eg_l || !ldr_req) m_streak = 0;
            else if (eg_c)        m_streak = m_streak + 1;
            if (eg_l)      m_last_ldr = 1'b1;
            else if (eg_c) m_last_ldr = 1'b0;
        end
        #1;
    endtask

    initial begin
        int nlocked;
        bit got;
        bit exp_l;

        n_checks   = 0;
        n_fail     = 0;
        m_locked   = 1'b0;
        m_streak   = 0;
        m_last_ldr = 1'b1;
        m_pv       = 1'b0;
        m_pl       = 1'b0;
        m_pd       = '0;

        // Reset held with both requesters active
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; cpu_wdata = 16'h0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0002; ldr_wdata = 16'h0;
        ldr_lock = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_no_gnt", 32'(o_cg | o_lg), 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("rst_release_cpu", 32'(o_cg), 32'd1);

        // CPU write then read back
        ldr_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
        tick();
        chk("wr_gnt", 32'(o_cg), 32'd1);
        cpu_we = 1'b0;
        tick();
        chk("rd_gnt", 32'(o_cg), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("rd_rvalid", 32'(o_crv), 32'd1);
        chk("rd_data", 32'(o_crd), 32'h1234);
        chk("rd_ldr_rvalid", 32'(o_lrv), 32'd0);

        // Continuous contention
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0040;
        for (int i = 0; i < 27; i++) begin
            tick();
`ifdef MEM_ARB_RR_EN
            exp_l = (i % 2 == 0);
`else
            exp_l = (i % 9 == 8);
`endif
            chk("contend_seq", 32'(o_lg), 32'(exp_l));
        end

        // Loader lock: acquire under contention, then sixteen uninterrupted writes
        cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h5555;
        ldr_we = 1'b1; ldr_addr = 16'h0000; ldr_wdata = 16'hA000; ldr_lock = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = o_lg;
        end
        chk("lock_acquire", 32'(got), 32'd1);
        nlocked = got ? 1 : 0;
        for (int k = 1; k < 16; k++) begin
            ldr_addr  = 16'(k);
            ldr_wdata = 16'hA000 + 16'(k);
            tick();
            if (o_lg && !o_cg) nlocked++;
        end
        chk("lock_run", 32'(nlocked), 32'd16);
        ldr_lock = 1'b0; ldr_addr = 16'h0010;
        tick();
        chk("unlock_cpu", 32'(o_cg), 32'd1);
        ldr_req = 1'b0;
        cpu_we = 1'b0; cpu_addr = 16'h0005;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("lock_data", 32'(o_crd), 32'hA005);

        // Reset during an outstanding loader read, with the lock taken
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0003; ldr_lock = 1'b1;
        tick();
        chk("mr_gnt", 32'(o_lg), 32'd1);
        reset = 1'b1; ldr_req = 1'b0;
        tick();
        chk("mr_no_rvalid", 32'(o_lrv), 32'd0);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        ldr_req = 1'b1;
        tick();
        chk("mr_free_cpu", 32'(o_cg), 32'd1);

        // Random traffic; a waiting requester holds its fields
        for (int i = 0; i < 3000; i++) begin
            if (!(cpu_req && !o_cg)) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 31));
                cpu_wdata = 16'($urandom);
            end
            if (!(ldr_req && !o_lg)) begin
                ldr_req   = ($urandom_range(0, 2) != 0);
                ldr_we    = 1'($urandom_range(0, 1));
                ldr_addr  = 16'($urandom_range(0, 31));
                ldr_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) ldr_lock = !ldr_lock;
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        reset = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
